// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the byte-wise generator and receive checker.
// Reflected polynomial, preset/residue constants, one-byte step function and FSM state type.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic {IDLE, ACTIVE} crc32_state_e;

    // Eight LSB-first shift steps after folding the byte into the low bits.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic [7:0]  data,
                                               input logic [31:0] poly = CRC32_POLY);
        logic [31:0] c;
        c = crc ^ {24'b0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_fcs_strip.sv
// Four-byte delay line that withholds the trailing FCS and releases payload bytes.
// start_i restarts the line with the current byte; eop_i releases the oldest byte as last.
module crc32_fcs_strip (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       start_i,
    input  logic       eop_i,
    input  logic [7:0] data_i,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    output logic       out_last_o
);

    logic [3:0][7:0] dly_q, dly_d;
    logic [2:0]      fill_q, fill_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;

    always_comb begin
        dly_d       = dly_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_last_d  = 1'b0;
        if (start_i) begin
            // Anything still held belongs to an abandoned frame and is dropped.
            dly_d[0] = data_i;
            fill_d   = eop_i ? 3'd0 : 3'd1;
        end else if (push_i) begin
            if (fill_q == 3'd4) begin
                out_valid_d = 1'b1;
                out_data_d  = dly_q[3];
                out_last_d  = eop_i;
            end
            dly_d = {dly_q[2:0], data_i};
            if (eop_i) begin
                fill_d = 3'd0;
            end else if (fill_q != 3'd4) begin
                fill_d = fill_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q       <= '0;
            fill_q      <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            dly_q       <= dly_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

endmodule

// File: rtl/crc32_rx_checker.sv
// Receive CRC-32 checker: residue check over payload+FCS, FCS stripping, per-frame status.
// Optional good/bad frame counters when CRC_STATS_EN is defined.
module crc32_rx_checker
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter logic [31:0] INIT    = CRC32_INIT,
`ifdef CRC_STATS_EN
    parameter int unsigned STAT_W  = 16,
`endif
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              frame_done,
    output logic              crc_ok,
    output logic              runt_err,
`ifdef CRC_STATS_EN
    output logic [STAT_W-1:0] good_cnt,
    output logic [STAT_W-1:0] bad_cnt,
`endif
    output logic              abort_err
);

    crc32_state_e state_q, state_d;
    logic [31:0]  crc_q, crc_d, crc_new;
    logic [2:0]   cnt_q, cnt_d;
    logic         done_q, done_d;
    logic         ok_q, ok_d;
    logic         runt_q, runt_d;
    logic         abort_q, abort_d;
    logic         strip_push, strip_start, strip_eop;

    // A sop byte always reseeds, whether it opens a frame or aborts one.
    assign crc_new = crc32_step(in_sop ? INIT : crc_q, in_data, POLY);

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        runt_d      = 1'b0;
        abort_d     = 1'b0;
        strip_push  = 1'b0;
        strip_start = 1'b0;
        strip_eop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_sop) begin
                    crc_d       = crc_new;
                    cnt_d       = 3'd1;
                    strip_start = 1'b1;
                    strip_eop   = in_eop;
                    if (in_eop) begin
                        done_d = 1'b1;
                        runt_d = 1'b1;
                        cnt_d  = 3'd0;
                    end else begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (in_valid) begin
                    crc_d = crc_new;
                    if (in_sop) begin
                        cnt_d       = 3'd1;
                        strip_start = 1'b1;
                        done_d      = 1'b1;
                        abort_d     = 1'b1;
                        // Only one status slot: a 1-byte frame that aborts another is dropped.
                        if (in_eop) begin
                            state_d   = IDLE;
                            strip_eop = 1'b1;
                            cnt_d     = 3'd0;
                        end
                    end else begin
                        strip_push = 1'b1;
                        cnt_d      = (cnt_q == 3'd5) ? 3'd5 : cnt_q + 3'd1;
                        if (in_eop) begin
                            state_d   = IDLE;
                            strip_eop = 1'b1;
                            done_d    = 1'b1;
                            runt_d    = (cnt_q < 3'd3);
                            ok_d      = (cnt_q >= 3'd3) && (crc_new == RESIDUE);
                            cnt_d     = 3'd0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            runt_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            runt_q  <= runt_d;
            abort_q <= abort_d;
        end
    end

    crc32_fcs_strip u_strip (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (strip_push),
        .start_i     (strip_start),
        .eop_i       (strip_eop),
        .data_i      (in_data),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

    assign frame_done = done_q;
    assign crc_ok     = ok_q;
    assign runt_err   = runt_q;
    assign abort_err  = abort_q;

`ifdef CRC_STATS_EN
    logic [STAT_W-1:0] good_q, bad_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (done_q) begin
            if (ok_q) begin
                if (good_q != '1) good_q <= good_q + 1'b1;
            end else begin
                if (bad_q != '1) bad_q <= bad_q + 1'b1;
            end
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_crc32_rx_checker.sv
// Bench for crc32_rx_checker: directed vector table, reset-mid-frame sequence and
// randomized frames compared against a frame-level reference model.
module tb_crc32_rx_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_sop, in_eop;
    logic [7:0] in_data;
    logic       out_valid, out_last, frame_done, crc_ok, runt_err, abort_err;
    logic [7:0] out_data;
`ifdef CRC_STATS_EN
    logic [15:0] good_cnt, bad_cnt;
`endif

    always #5 clk = ~clk;

    crc32_rx_checker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .runt_err   (runt_err),
`ifdef CRC_STATS_EN
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt),
`endif
        .abort_err  (abort_err)
    );

    typedef struct {
        logic       v, s, e;
        logic [7:0] d;
        logic       ov;
        logic [7:0] od;
        logic       ol, fd, ok, rt, ab;
    } vec_t;

    vec_t       vecs[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] gf[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                           8'h26, 8'h39, 8'hF4, 8'hCB};

    // Reference model state and expected outputs for the following cycle.
    logic [7:0] m_frame[$];
    bit         m_in_frame = 0;
    logic       e_ov, e_ol, e_fd, e_ok, e_rt, e_ab;
    logic [7:0] e_od;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        if (e_ov) chk({tag, ".out_data"}, 32'(out_data), 32'(e_od));
        chk({tag, ".out_last"}, 32'(out_last), 32'(e_ol));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
        chk({tag, ".crc_ok"}, 32'(crc_ok), 32'(e_ok));
        chk({tag, ".runt_err"}, 32'(runt_err), 32'(e_rt));
        chk({tag, ".abort_err"}, 32'(abort_err), 32'(e_ab));
    endtask

    // Standard CRC-32, one bit at a time; returns the transmitted (inverted) value.
    function automatic logic [31:0] ref_crc(input logic [7:0] b[$], input int n);
        logic [31:0] r;
        bit          fb;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = b[i][j] ^ r[0];
                r  = r >> 1;
                if (fb) r = r ^ 32'hEDB88320;
            end
        end
        return ~r;
    endfunction

    function automatic bit frame_good(input logic [7:0] f[$]);
        int          n;
        logic [31:0] c;
        n = f.size();
        if (n < 4) return 0;
        c = ref_crc(f, n - 4);
        return {f[n-1], f[n-2], f[n-3], f[n-4]} == c;
    endfunction

    task automatic model_step(input logic v, input logic s, input logic e, input logic [7:0] d);
        int n;
        {e_ov, e_ol, e_fd, e_ok, e_rt, e_ab} = '0;
        e_od = 8'h00;
        if (!v) return;
        if (s) begin
            if (m_in_frame) begin
                e_fd = 1;
                e_ab = 1;
            end
            m_frame.delete();
            m_frame.push_back(d);
            m_in_frame = 1;
            if (e) begin
                e_fd = 1;
                e_rt = 1;
                m_in_frame = 0;
            end
        end else if (m_in_frame) begin
            m_frame.push_back(d);
            n = m_frame.size();
            if (n >= 5) begin
                e_ov = 1;
                e_od = m_frame[n-5];
                e_ol = e;
            end
            if (e) begin
                e_fd = 1;
                e_rt = (n < 4);
                e_ok = frame_good(m_frame);
                m_in_frame = 0;
            end
        end
    endtask

    task automatic apply(input logic v, input logic s, input logic e, input logic [7:0] d);
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic drive_model(input logic v, input logic s, input logic e, input logic [7:0] d);
        if (v && s && e && m_in_frame) e = 0;
        model_step(v, s, e, d);
        apply(v, s, e, d);
        check_outputs("rnd");
    endtask

    task automatic add(input logic v, input logic s, input logic e, input logic [7:0] d,
                       input logic ov, input logic [7:0] od, input logic ol,
                       input logic fd, input logic ok, input logic rt, input logic ab);
        vec_t r;
        r = '{v: v, s: s, e: e, d: d, ov: ov, od: od, ol: ol, fd: fd, ok: ok, rt: rt, ab: ab};
        vecs.push_back(r);
    endtask

    task automatic add_idle();
        add(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
    endtask

    // "123456789" + FCS; payload byte i-4 appears after byte i.
    task automatic add_good(input logic [7:0] last, input logic ok_exp, input logic abort_first,
                            input bit gap);
        logic [7:0] b;
        for (int i = 0; i < 13; i++) begin
            b = (i == 12) ? last : gf[i];
            add(1, i == 0, i == 12, b, i >= 4, (i >= 4) ? gf[i-4] : 8'h00, i == 12,
                (i == 12) || (i == 0 && abort_first), (i == 12) && ok_exp, 0,
                (i == 0) && abort_first);
            if (gap && i == 6) add_idle();
        end
    endtask

    initial begin
        logic [7:0]  fr[$];
        logic [31:0] c;
        int          kind, p, idx, last;
        bit          abort;
        vec_t        r;

        rst = 1;
        in_valid = 0; in_sop = 0; in_eop = 0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        {e_ov, e_ol, e_fd, e_ok, e_rt, e_ab} = '0;
        e_od = 8'h00;
        check_outputs("reset");
        chk("reset.out_data", 32'(out_data), 32'h0);
        rst = 0;

        // Directed table
        add(1, 0, 1, 8'h55, 0, 8'h00, 0, 0, 0, 0, 0);
        add_good(8'hCB, 1, 0, 0);
        add_idle();
        add_good(8'hCA, 0, 0, 0);
        add_idle();
        add(1, 1, 0, 8'hAA, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'hBB, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 1, 8'hCC, 0, 8'h00, 0, 1, 0, 1, 0);
        add(1, 1, 1, 8'hDD, 0, 8'h00, 0, 1, 0, 1, 0);
        add(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 1, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0);
        add(1, 1, 0, 8'hA1, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'hA2, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'hA3, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'hA4, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'hA5, 1, 8'hA1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'hA6, 1, 8'hA2, 0, 0, 0, 0, 0);
        add_good(8'hCB, 1, 1, 0);
        add_good(8'hCB, 1, 0, 1);
        add_idle();

        for (int k = 0; k < vecs.size(); k++) begin
            r = vecs[k];
            apply(r.v, r.s, r.e, r.d);
            {e_ov, e_od, e_ol, e_fd, e_ok, e_rt, e_ab} = {r.ov, r.od, r.ol, r.fd, r.ok, r.rt, r.ab};
            check_outputs($sformatf("vec%0d", k));
        end

        // Reset in the middle of a frame
        m_in_frame = 0;
        for (int i = 0; i < 5; i++) drive_model(1, i == 0, 0, gf[i]);
        rst = 1;
        in_valid = 0; in_sop = 0; in_eop = 0;
        #1;
        {e_ov, e_ol, e_fd, e_ok, e_rt, e_ab} = '0;
        check_outputs("rst_mid");
        @(negedge clk);
        check_outputs("rst_mid_hold");
        rst = 0;
        m_in_frame = 0;
        for (int i = 0; i < 13; i++) drive_model(1, i == 0, i == 12, gf[i]);
        chk("post_rst.crc_ok", 32'(crc_ok), 32'h1);
        drive_model(0, 0, 0, 8'h00);
`ifdef CRC_STATS_EN
        chk("post_rst.good_cnt", 32'(good_cnt), 32'd1);
        chk("post_rst.bad_cnt", 32'(bad_cnt), 32'd0);
`endif

        // Randomized frames
        for (int f = 0; f < 300; f++) begin
            fr.delete();
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                p = $urandom_range(1, 3);
                for (int i = 0; i < p; i++) fr.push_back(8'($urandom));
            end else begin
                p = $urandom_range(0, 8);
                for (int i = 0; i < p; i++) fr.push_back(8'($urandom));
                c = ref_crc(fr, p);
                fr.push_back(c[7:0]);
                fr.push_back(c[15:8]);
                fr.push_back(c[23:16]);
                fr.push_back(c[31:24]);
                if (kind == 1) begin
                    idx = $urandom_range(0, fr.size() - 1);
                    fr[idx] = fr[idx] ^ 8'(1 << $urandom_range(0, 7));
                end
            end
            abort = (kind == 2) && (fr.size() >= 2);
            last  = abort ? fr.size() - 2 : fr.size() - 1;
            for (int i = 0; i <= last; i++) begin
                drive_model(1, i == 0, (i == last) && !abort, fr[i]);
                if ($urandom_range(0, 4) == 0)
                    drive_model(0, 1'($urandom), 1'($urandom), 8'($urandom));
            end
            repeat ($urandom_range(0, 2))
                drive_model($urandom_range(0, 3) == 0, 0, 0, 8'($urandom));
        end
        drive_model(0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
